fpmat_stream_tx: RTL and testbench
==================================

// Module: fpmat_stream_tx
// PURPOSE
// - Converts one flattened fixed-point matrix, such as an FPMatMul result, into a stream of single elements.
// - Flat bus layout: element (i,j) occupies bits [W*(i*COLS+j+1)-1 : W*(i*COLS+j)].
// - Capture uses a valid/ready handshake. Elements leave one per cycle under a valid/ready handshake.
// - Emission order is row-major, or column-major when TRANSPOSE=1, so the next FPMatMul's in_2 can be fed directly.
// PARAMETERS
// - DATA_WIDTH   16  bits per element (half integer, half fraction; passed through unmodified)
// - ROWS          8  matrix rows, >=1
// - COLS          8  matrix columns, >=1
// - TRANSPOSE     0  0: row-major emission; 1: column-major emission
// PORTS
// - clk            in   1                    rising-edge clock
// - rst            in   1                    synchronous reset, active-high
// - in_mat         in   DATA_WIDTH*ROWS*COLS  flattened matrix
// - in_valid       in   1                    in_mat is valid
// - in_ready       out  1                    block can capture in_mat this cycle
// - out_data       out  DATA_WIDTH           current element
// - out_valid      out  1                    out_data is valid
// - out_ready      in   1                    consumer accepts out_data
// - out_row_idx    out  max(1,$clog2(ROWS))  row index i of out_data
// - out_col_idx    out  max(1,$clog2(COLS))  column index j of out_data
// - out_line_last  out  1                    last element of a row (TRANSPOSE=0) or of a column (TRANSPOSE=1)
// - out_mat_last   out  1                    last element of the matrix
// BEHAVIOUR
// - States:
//   - IDLE: no matrix held.
//   - STREAM: matrix held, emitting elements.
// - Reset: state=IDLE, holding register=0, both indices=0. All outputs are 0 while rst=1, including in_ready.
// - in_ready is combinational:
//   - high in IDLE;
//   - high in STREAM only during the cycle in which the final element handshakes (out_valid & out_ready & out_mat_last).
// - Capture occurs when in_valid & in_ready at edge k:
//   - in_mat is copied to the holding register, indices are set to (0,0), state becomes STREAM.
//   - out_valid=1 from cycle k+1, giving 1-cycle latency.
// - In STREAM, out_valid=1. out_data is the held element at (out_row_idx, out_col_idx), muxed from the register with no added latency.
// - Stall: when out_valid & !out_ready, out_data and all index/last outputs hold stable.
// - Advance on handshake:
//   - TRANSPOSE=0: col++. At col=COLS-1, col wraps to 0 and row++.
//   - TRANSPOSE=1: row++. At row=ROWS-1, row wraps to 0 and col++.
// - Flag definitions:
//   - out_line_last, TRANSPOSE=0: col==COLS-1.
//   - out_line_last, TRANSPOSE=1: row==ROWS-1.
//   - out_mat_last: row==ROWS-1 && col==COLS-1.
// - Final handshake without a new capture: state goes to IDLE, out_valid=0 next cycle, indices return to 0.
// - Final handshake with a simultaneous capture (in_valid=1): the new matrix is captured, state stays STREAM, indices go to (0,0).
//   - Streaming is back-to-back with zero bubbles.
// - in_valid while in STREAM and not at the final handshake: ignored. The holding register is not overwritten.
// - ROWS=COLS=1: every element asserts both out_line_last and out_mat_last.
// - Reset mid-stream: the stream aborts immediately. The next cycle is IDLE with out_valid=0, and the partial matrix is discarded.
// - No arithmetic; element width is unchanged. Index counters are exact-width and never exceed ROWS-1 / COLS-1.
// STRUCTURE
// - Shared package fpmat_pkg:
//   - state encoding (IDLE=1'b0, STREAM=1'b1);
//   - index-width constant functions: clog2 helper with minimum width 1;
//   - the flat-bus element offset function W*(i*COLS+j).
// - One sub-module, fpmat_idx_counter:
//   - 2-D wrap counter with params (ROWS, COLS, TRANSPOSE);
//   - inputs clear and advance;
//   - outputs row, col, line_last, mat_last.
// - Top level contains the FSM, the holding register and the element mux.
// TESTING
// Configuration for every scenario: DATA_WIDTH=16, ROWS=2, COLS=3. in_mat elements 0x0001..0x0006 at flat indices 0..5.
// 1. Row-major, out_ready=1:
//    - sequence 1,2,3,4,5,6;
//    - out_line_last on 3 and 6, out_mat_last on 6 only;
//    - first out_valid 1 cycle after capture; IDLE afterwards.
// 2. TRANSPOSE=1, out_ready=1:
//    - sequence 1,4,2,5,3,6;
//    - indices (0,0),(1,0),(0,1),(1,1),(0,2),(1,2);
//    - out_line_last on 4, 5 and 6.
// 3. Backpressure: out_ready toggles 1,0,0,1,...
//    - out_data and indices are held stable during each stall;
//    - no element is lost or duplicated; sequence still 1..6.
// 4. Back-to-back: second matrix 0x0011..0x0016 with in_valid held high.
//    - in_ready pulses only on the beat carrying 6;
//    - 0x0011 follows 6 on the next cycle with no gap;
//    - in_valid during the first matrix does not corrupt it.
// 5. Reset mid-stream: rst=1 for 1 cycle after element 3 is accepted.
//    - next cycle: out_valid=0, in_ready=1;
//    - a new capture restarts at element (0,0).
// 6. Degenerate ROWS=COLS=1: element 0x00AB.
//    - single beat with out_line_last=out_mat_last=1;
//    - in_ready is high during that handshake.

Source files
------------

// File: rtl/fpmat_stream_tx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fpmat_pkg : shared state encoding and index/offset helpers      |
// | Revision  : 1.0                                                 |
// +-----------------------------------------------------------------+
package fpmat_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Index width with a floor of one bit so a single row/column still has a port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int elem_offset(input int w, input int cols, input int i, input int j);
    return w * (i * cols + j);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpmat_stream_tx_idx_counter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fpmat_idx_counter : 2-D wrap counter, row- or column-major      |
// | Revision          : 1.0                                         |
// +-----------------------------------------------------------------+
module fpmat_idx_counter
  import fpmat_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int TRANSPOSE = 0,
  parameter int RW        = idx_width(ROWS),
  parameter int CW        = idx_width(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          line_last,
  output logic          mat_last
);

  localparam logic [RW-1:0] C_ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          row_at_max;
  logic          col_at_max;

  assign row_at_max = (row_q == C_ROW_MAX);
  assign col_at_max = (col_q == C_COL_MAX);

  // The slow axis wraps together with the fast one, so the final step lands on (0,0).
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (TRANSPOSE == 0) begin
        col_d = col_at_max ? '0 : col_q + CW'(1);
        if (col_at_max) begin
          row_d = row_at_max ? '0 : row_q + RW'(1);
        end
      end else begin
        row_d = row_at_max ? '0 : row_q + RW'(1);
        if (row_at_max) begin
          col_d = col_at_max ? '0 : col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  generate
    if (TRANSPOSE == 0) begin : g_row_major
      assign line_last = col_at_max;
    end else begin : g_col_major
      assign line_last = row_at_max;
    end
  endgenerate

  assign row      = row_q;
  assign col      = col_q;
  assign mat_last = row_at_max & col_at_max;

endmodule
`default_nettype wire

// File: rtl/fpmat_stream_tx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fpmat_stream_tx : captures a flat matrix, streams its elements  |
// | Revision        : 1.0                                           |
// +-----------------------------------------------------------------+
module fpmat_stream_tx
  import fpmat_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int TRANSPOSE  = 0,
  localparam int RW        = idx_width(ROWS),
  localparam int CW        = idx_width(COLS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH*ROWS*COLS-1:0] in_mat,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RW-1:0]                out_row_idx,
  output logic [CW-1:0]                out_col_idx,
  output logic                         out_line_last,
  output logic                         out_mat_last
);

  localparam int C_MAT_W = DATA_WIDTH * ROWS * COLS;

  state_e                state_q, state_d;
  logic [C_MAT_W-1:0]    mat_q, mat_d;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  line_last;
  logic                  mat_last;
  logic                  streaming;
  logic                  out_fire;
  logic                  final_fire;
  logic                  capture;
  logic                  ready_int;
  logic [DATA_WIDTH-1:0] elem [ROWS][COLS];

  assign streaming  = (state_q == ST_STREAM);
  assign out_fire   = streaming & out_ready;
  assign final_fire = out_fire & mat_last;
  assign ready_int  = (state_q == ST_IDLE) | final_fire;
  assign capture    = in_valid & ready_int & ~rst;

  always_comb begin
    state_d = state_q;
    mat_d   = mat_q;
    if (capture) begin
      state_d = ST_STREAM;
      mat_d   = in_mat;
    end else if (final_fire) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      mat_q   <= mat_d;
    end
  end

  fpmat_idx_counter #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .TRANSPOSE (TRANSPOSE),
    .RW        (RW),
    .CW        (CW)
  ) u_idx (
    .clk       (clk),
    .rst       (rst),
    .clear     (capture),
    .advance   (out_fire),
    .row       (row),
    .col       (col),
    .line_last (line_last),
    .mat_last  (mat_last)
  );

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
        assign elem[gi][gj] = mat_q[elem_offset(DATA_WIDTH, COLS, gi, gj) +: DATA_WIDTH];
      end
    end
  endgenerate

  // Every output is forced low while reset is asserted, including in_ready.
  assign in_ready      = ~rst & ready_int;
  assign out_valid     = ~rst & streaming;
  assign out_data      = rst ? '0 : elem[row][col];
  assign out_row_idx   = rst ? '0 : row;
  assign out_col_idx   = rst ? '0 : col;
  assign out_line_last = ~rst & line_last;
  assign out_mat_last  = ~rst & mat_last;

endmodule
`default_nettype wire

// File: tb/tb_fpmat_stream_tx.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_fpmat_stream_tx : directed bench, 2x3 row/col-major and 1x1  |
// | Revision           : 1.0                                        |
// +-----------------------------------------------------------------+
module tb_fpmat_stream_tx;

  localparam logic [95:0] M1 = 96'h0006_0005_0004_0003_0002_0001;
  localparam logic [95:0] M2 = 96'h0016_0015_0014_0013_0012_0011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [95:0] a_in_mat;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_line_last, a_mat_last;
  logic [15:0] a_out_data;
  logic [0:0]  a_row;
  logic [1:0]  a_col;

  logic [95:0] b_in_mat;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_line_last, b_mat_last;
  logic [15:0] b_out_data;
  logic [0:0]  b_row;
  logic [1:0]  b_col;

  logic [15:0] c_in_mat;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_line_last, c_mat_last;
  logic [15:0] c_out_data;
  logic [0:0]  c_row;
  logic [0:0]  c_col;

  fpmat_stream_tx #(.DATA_WIDTH(16), .ROWS(2), .COLS(3), .TRANSPOSE(0)) dut_a (
    .clk(clk), .rst(rst), .in_mat(a_in_mat), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_row_idx(a_row), .out_col_idx(a_col), .out_line_last(a_line_last), .out_mat_last(a_mat_last));

  fpmat_stream_tx #(.DATA_WIDTH(16), .ROWS(2), .COLS(3), .TRANSPOSE(1)) dut_b (
    .clk(clk), .rst(rst), .in_mat(b_in_mat), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_row_idx(b_row), .out_col_idx(b_col), .out_line_last(b_line_last), .out_mat_last(b_mat_last));

  fpmat_stream_tx #(.DATA_WIDTH(16), .ROWS(1), .COLS(1), .TRANSPOSE(0)) dut_c (
    .clk(clk), .rst(rst), .in_mat(c_in_mat), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_row_idx(c_row), .out_col_idx(c_col), .out_line_last(c_line_last), .out_mat_last(c_mat_last));

  // Beat layout: {valid, data, row, col, line_last, mat_last}
  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last} !== 23'd0) begin
      errors++; $display("FAIL reset_a_outputs_zero got %h exp 0",
        {a_in_ready, a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last});
    end
    checks++;
    if ({c_in_ready, c_out_valid, c_line_last, c_mat_last} !== 4'd0) begin
      errors++; $display("FAIL reset_c_outputs_zero got %b exp 0000",
        {c_in_ready, c_out_valid, c_line_last, c_mat_last});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_row, a_col, b_in_ready, b_out_valid} !== 7'b10_0_00_10) begin
      errors++; $display("FAIL reset_idle_state got %b exp 1000010",
        {a_in_ready, a_out_valid, a_row, a_col, b_in_ready, b_out_valid});
    end
  endtask

  task automatic test_row_major();
    logic [21:0] exp_beat;
    a_out_ready = 1'b1; a_in_mat = M1; a_in_valid = 1'b1;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      errors++; $display("FAIL rm_pre_capture got %b exp 10", {a_in_ready, a_out_valid});
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_beat = {1'b1, 16'(k + 1), 1'((k / 3)), 2'((k % 3)), ((k % 3) == 2), (k == 5)};
      #1;
      checks++;
      if ({a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last} !== exp_beat) begin
        errors++; $display("FAIL rm_beat%0d got %h exp %h", k,
          {a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last}, exp_beat);
      end
      checks++;
      if (a_in_ready !== (k == 5)) begin
        errors++; $display("FAIL rm_in_ready%0d got %b exp %b", k, a_in_ready, (k == 5));
      end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if ({a_out_valid, a_in_ready, a_row, a_col} !== 5'b01_0_00) begin
      errors++; $display("FAIL rm_back_to_idle got %b exp 01000", {a_out_valid, a_in_ready, a_row, a_col});
    end
  endtask

  task automatic test_transpose();
    logic [21:0] exp_beat;
    int r, c;
    b_out_ready = 1'b1; b_in_mat = M1; b_in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      r = k % 2;
      c = k / 2;
      exp_beat = {1'b1, 16'(r * 3 + c + 1), 1'(r), 2'(c), (r == 1), (k == 5)};
      #1;
      checks++;
      if ({b_out_valid, b_out_data, b_row, b_col, b_line_last, b_mat_last} !== exp_beat) begin
        errors++; $display("FAIL tr_beat%0d got %h exp %h", k,
          {b_out_valid, b_out_data, b_row, b_col, b_line_last, b_mat_last}, exp_beat);
      end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if ({b_out_valid, b_in_ready} !== 2'b01) begin
      errors++; $display("FAIL tr_back_to_idle got %b exp 01", {b_out_valid, b_in_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] exp_beat;
    int n = 0;
    a_in_mat = M1; a_in_valid = 1'b1; a_out_ready = 1'b0;
    #1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    // The expected element only moves on a handshake, so every stall cycle re-checks the held beat.
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      a_out_ready = ((cyc % 3) == 0);
      exp_beat = {1'b1, 16'(n + 1), 1'((n / 3)), 2'((n % 3)), ((n % 3) == 2), (n == 5)};
      #1;
      checks++;
      if ({a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last} !== exp_beat) begin
        errors++; $display("FAIL bp_cycle%0d got %h exp %h", cyc,
          {a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last}, exp_beat);
      end
      if (a_out_ready) n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n !== 6) begin
      errors++; $display("FAIL bp_element_count got %0d exp 6", n);
    end
    a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_back_to_idle got %b exp 0", a_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp_beat;
    int kk;
    a_in_mat = M1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    a_in_mat = M2;
    for (int k = 0; k < 12; k++) begin
      kk = k % 6;
      exp_beat = {1'b1, (k < 6) ? 16'(kk + 1) : 16'(16'h0011 + kk), 1'((kk / 3)), 2'((kk % 3)),
                  ((kk % 3) == 2), (kk == 5)};
      #1;
      checks++;
      if ({a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last} !== exp_beat) begin
        errors++; $display("FAIL b2b_beat%0d got %h exp %h", k,
          {a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last}, exp_beat);
      end
      if (k < 6) begin
        checks++;
        if (a_in_ready !== (k == 5)) begin
          errors++; $display("FAIL b2b_in_ready%0d got %b exp %b", k, a_in_ready, (k == 5));
        end
      end
      @(posedge clk); #1;
      if (k == 5) a_in_valid = 1'b0;
    end
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_back_to_idle got %b exp 0", a_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    a_in_mat = M1; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({a_out_valid, a_out_data} !== {1'b1, 16'(k + 1)}) begin
        errors++; $display("FAIL rst_mid_pre%0d got %h exp %h", k, {a_out_valid, a_out_data}, {1'b1, 16'(k + 1)});
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({a_in_ready, a_out_valid, a_out_data} !== 18'd0) begin
      errors++; $display("FAIL rst_mid_during got %h exp 0", {a_in_ready, a_out_valid, a_out_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      errors++; $display("FAIL rst_mid_after got %b exp 01", {a_out_valid, a_in_ready});
    end
    a_in_mat = M2; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last} !== {1'b1, 16'h0011, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rst_mid_restart got %h exp %h",
        {a_out_valid, a_out_data, a_row, a_col, a_line_last, a_mat_last}, {1'b1, 16'h0011, 1'b0, 2'd0, 1'b0, 1'b0});
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_drain got %b exp 0", a_out_valid);
    end
  endtask

  task automatic test_degenerate();
    c_in_mat = 16'h00AB; c_in_valid = 1'b1; c_out_ready = 1'b1;
    #1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    #1;
    checks++;
    if ({c_out_valid, c_out_data, c_row, c_col, c_line_last, c_mat_last} !== {1'b1, 16'h00AB, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL deg_beat got %h exp %h",
        {c_out_valid, c_out_data, c_row, c_col, c_line_last, c_mat_last}, {1'b1, 16'h00AB, 1'b0, 1'b0, 1'b1, 1'b1});
    end
    checks++;
    if (c_in_ready !== 1'b1) begin
      errors++; $display("FAIL deg_in_ready got %b exp 1", c_in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (c_out_valid !== 1'b0) begin
      errors++; $display("FAIL deg_back_to_idle got %b exp 0", c_out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_mat = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_mat = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    c_in_mat = '0; c_in_valid = 1'b0; c_out_ready = 1'b0;
    test_reset();
    test_row_major();
    test_transpose();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
